lpmul_arb: RTL and testbench
============================

// Module: lpmul_arb
// PURPOSE
//  Shares one SPARROW 8-bit lpmul datapath among NREQ requesters (vector lanes/issue ports).
//  - Arbitration: round-robin, one multiply accepted per cycle.
//  - Result: registered with the winning requester's id, on a valid/ready response channel.
//  - Also counts stall cycles for performance monitoring.
//  - Sits between lane issue logic and the shared multiplier.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  IDW   2   requester id width, $clog2(NREQ)
//  CNTW  16  stall counter width
// PORTS
//  clk        in   1              clock; all state on rising edge
//  rst        in   1              asynchronous, active-high reset
//  req_valid  in   NREQ           requester i presents an operation
//  req_ready  out  NREQ           one-hot accept; handshake = valid[i] & ready[i]
//  req_op     in   NREQ x lpmul_in_type  per-requester {opA, opB, sign, sat}
//  resp_valid out  1              result register holds a result
//  resp_ready in   1              consumer takes the result
//  resp_id    out  IDW            requester that issued the result
//  resp_res   out  16 (high_prec_component)  lpmul mul_res of that operation
//  stat_clr   in   1              synchronous clear of stall_cnt
//  stall_cnt  out  CNTW           saturating count of stalled cycles
// BEHAVIOUR
//  - Reset: resp_valid=0, resp_id=0, resp_res=0, rr_ptr=0, stall_cnt=0. Effective immediately.
//    An operation in flight is discarded, not replayed.
//  - accept = !resp_valid | resp_ready. The output register is a 1-deep pipe that refills on drain.
//  - Grant: scan the NREQ slots starting at rr_ptr; grant the first i with req_valid[i].
//    - req_ready[i] = grant[i] & accept. The grant is combinational.
//    - A combinational path resp_ready -> req_ready is permitted.
//    - req_ready is all-zero when no request is valid or accept=0.
//  - Handshake with requester i at cycle N:
//    - lpmul is driven with req_op[i] during cycle N.
//    - At edge N+1: resp_valid=1, resp_id=i, resp_res=mul_res.
//    - Latency is 1 cycle. Throughput is 1 per cycle while resp_ready=1.
//    - rr_ptr <= (i+1) mod NREQ. rr_ptr changes only on a handshake.
//  - No handshake and resp_ready & resp_valid: resp_valid <= 0. resp_id/resp_res hold their last values.
//  - resp_valid & !resp_ready: resp_id and resp_res stay stable, and no request is accepted.
//  - Idle cycles: the lpmul input is driven with zeros (opA=opB=0, sign=sat=0).
//  - Arithmetic is exactly lpmul's:
//    - unsigned or signed 8x8 -> 16;
//    - optional saturation to 0x007F (signed max), 0xFF80 (signed min), 0x00FF (unsigned max).
//    - This block never alters the product.
//  - Stall counting:
//    - stall_cnt += 1 when |req_valid & !accept; it saturates at 2^CNTW-1 (no wrap).
//    - stat_clr has priority: the cycle's increment is lost and the counter reads 0 next cycle.
//  - Requester obligations: req_op[i] is held stable and req_valid[i] is not dropped until accepted.
//    - A dropped request simply loses its slot; no error is raised.
//  - Simultaneous drain and accept in one cycle is legal and is the normal full-rate case.
// STRUCTURE
//  - Package sparrow gains:
//    - constants LPARB_NREQ=4, LPARB_IDW=2;
//    - typedef lpmul_arb_resp_type {logic [IDW-1:0] id; high_prec_component res;}.
//    - Existing lpmul_in_type, lpmul_out_type, vector_component and high_prec_component are reused.
//  - Sub-module: one lpmul instance (the shared datapath).
//  - Round-robin grant is a small function in this file; no separate arbiter module.
// TESTING
//  1 Reset: assert rst mid-stream -> same cycle resp_valid=0, stall_cnt=0.
//    After release, the first grant goes to requester 0.
//  2 Single request: req 2, opA=0x9C(-100), opB=0x03, sign=1, sat=1, resp_ready=1.
//    -> req_ready=0b0100; next cycle resp_valid=1, resp_id=2, resp_res=0xFF80.
//  3 Arithmetic pass-through:
//    - opA=100, opB=2, sign=1, sat=1 -> 0x007F;
//    - opA=15, opB=17, sign=0, sat=0 -> 0x00FF;
//    - opA=-100, opB=2, sign=1, sat=0 -> 0xFF38.
//  4 Contention: all 4 requesters valid continuously, resp_ready=1.
//    -> resp_id sequence 0,1,2,3,0,... one per cycle; no requester is granted twice before another.
//  5 Backpressure: a result is pending, resp_ready=0 for 5 cycles with 3 requests valid.
//    - resp_id/resp_res stable; req_ready=0; stall_cnt=5.
//    - On resp_ready=1 the next grant follows rr_ptr.
//  6 Counter: force 2^CNTW+3 stall cycles -> stall_cnt=0xFFFF.
//    Pulse stat_clr -> 0 next cycle, even while stalling.

Source files
------------

// File: rtl/lpmul_arb_pkg.sv
// Shared SPARROW types for the low-precision multiplier and its requester arbiter.
// Operand, product and response layouts used by the lanes and the shared lpmul.
package lpmul_arb_pkg;

    localparam int DATA_W     = 8;
    localparam int HI_W       = 2 * DATA_W;
    localparam int LPARB_NREQ = 4;
    localparam int LPARB_IDW  = 2;

    typedef logic [DATA_W-1:0] vector_component;
    typedef logic [HI_W-1:0]   high_prec_component;

    typedef struct packed {
        vector_component op_a;
        vector_component op_b;
        logic            sign;
        logic            sat;
    } lpmul_in_type;

    typedef struct packed {
        high_prec_component mul_res;
    } lpmul_out_type;

    typedef struct packed {
        logic [LPARB_IDW-1:0] id;
        high_prec_component   res;
    } lpmul_arb_resp_type;

endpackage

// File: rtl/lpmul_arb_if.sv
// Request/response bundle between lane issue logic and the shared multiplier arbiter.
interface lpmul_arb_if
    import lpmul_arb_pkg::*;
#(
    parameter int NREQ = LPARB_NREQ,
    parameter int IDW  = LPARB_IDW
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    lpmul_in_type       req_op [NREQ];
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    high_prec_component resp_res;

    modport master (
        output req_valid,
        output req_op,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_id,
        input  resp_res
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_id,
        output resp_res
    );

endinterface

// File: rtl/lpmul_arb_lpmul.sv
// SPARROW lpmul: combinational 8x8 -> 16 multiply, signed or unsigned, optional saturation.
module lpmul
    import lpmul_arb_pkg::*;
(
    input  lpmul_in_type  mul_in,
    output lpmul_out_type mul_out
);

    localparam int EXT_W  = DATA_W + 1;
    localparam int PROD_W = 2 * EXT_W;

    localparam logic signed [PROD_W-1:0] S_MAX = PROD_W'(127);
    localparam logic signed [PROD_W-1:0] S_MIN = -PROD_W'(128);
    localparam logic signed [PROD_W-1:0] U_MAX = PROD_W'(255);

    logic signed [EXT_W-1:0]  a_x;
    logic signed [EXT_W-1:0]  b_x;
    logic signed [PROD_W-1:0] prod;

    // Clamp to the 8-bit range of the operand type, sign-extended into the 16-bit result.
    function automatic high_prec_component sat16(input logic signed [PROD_W-1:0] p,
                                                 input logic sgn);
        high_prec_component r;
        r = p[HI_W-1:0];
        if (sgn) begin
            if (p > S_MAX)
                r = 16'h007F;
            else if (p < S_MIN)
                r = 16'hFF80;
        end else if (p > U_MAX) begin
            r = 16'h00FF;
        end
        return r;
    endfunction

    // One extra bit lets a single signed multiplier cover both operand modes.
    always_comb begin
        a_x  = mul_in.sign ? $signed({mul_in.op_a[DATA_W-1], mul_in.op_a})
                           : $signed({1'b0, mul_in.op_a});
        b_x  = mul_in.sign ? $signed({mul_in.op_b[DATA_W-1], mul_in.op_b})
                           : $signed({1'b0, mul_in.op_b});
        prod = a_x * b_x;
        mul_out.mul_res = mul_in.sat ? sat16(prod, mul_in.sign) : prod[HI_W-1:0];
    end

endmodule

// File: rtl/lpmul_arb.sv
// Round-robin sharing of one lpmul among NREQ lanes, with a 1-deep result register
// and a saturating stall counter for performance monitoring.
module lpmul_arb
    import lpmul_arb_pkg::*;
#(
    parameter int NREQ = LPARB_NREQ,
    parameter int IDW  = LPARB_IDW,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    lpmul_arb_if.slave      bus,
    input  logic            stat_clr,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic               accept;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    req_ready_c;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     rr_next;
    logic               hs;
    lpmul_in_type       sel_op;
    lpmul_in_type       mul_in;
    lpmul_out_type      mul_out;

    logic               vld_p1;
    logic [IDW-1:0]     id_p1;
    high_prec_component res_p1;

    // First valid slot at or after ptr, wrapping modulo NREQ.
    function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] req,
                                                 input logic [IDW-1:0]  ptr);
        logic [NREQ-1:0] g;
        g = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == (int'(ptr) + k) % NREQ && req[i] && g == '0)
                    g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    // Stage p0: grant, operand select and the shared multiply
    always_comb begin
        accept      = !vld_p1 || bus.resp_ready;
        grant       = rr_grant(bus.req_valid, rr_ptr);
        req_ready_c = accept ? grant : '0;
        hs          = |req_ready_c;
        gnt_idx     = '0;
        sel_op      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_idx = IDW'(i);
                sel_op  = bus.req_op[i];
            end
        end
        rr_next = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
        mul_in  = hs ? sel_op : '0;
    end

    lpmul u_lpmul (
        .mul_in  (mul_in),
        .mul_out (mul_out)
    );

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = vld_p1;
    assign bus.resp_id    = id_p1;
    assign bus.resp_res   = res_p1;

    // Stage p1: result register; a drain and a refill may happen in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
            res_p1 <= '0;
            rr_ptr <= '0;
        end else if (hs) begin
            vld_p1 <= 1'b1;
            id_p1  <= gnt_idx;
            res_p1 <= mul_out.mul_res;
            rr_ptr <= rr_next;
        end else if (bus.resp_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stat_clr)
            stall_cnt <= '0;
        else if (|bus.req_valid && !accept && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + CNTW'(1);
    end

endmodule

// File: tb/tb_lpmul_arb.sv
// Directed bench for lpmul_arb with an expected-result queue filled at issue time.
module tb_lpmul_arb;
    import lpmul_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stat_clr = 1'b0;
    logic [CNTW-1:0] stall_cnt;

    lpmul_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    lpmul_arb #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stat_clr  (stat_clr),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    lpmul_arb_resp_type sb[$];
    logic               m_valid;
    logic [IDW-1:0]     m_ptr;
    logic [IDW-1:0]     m_id;
    logic [15:0]        m_res;
    logic [CNTW-1:0]    m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_mul(input lpmul_in_type op);
        int a, b, p;
        if (op.sign) begin
            a = int'($signed(op.op_a));
            b = int'($signed(op.op_b));
        end else begin
            a = int'(op.op_a);
            b = int'(op.op_b);
        end
        p = a * b;
        if (op.sat) begin
            if (op.sign) begin
                if (p > 127) p = 127;
                if (p < -128) p = -128;
            end else if (p > 255) begin
                p = 255;
            end
        end
        return p[15:0];
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic sg, input logic st);
        bus.req_valid[i]    = 1'b1;
        bus.req_op[i].op_a  = a;
        bus.req_op[i].op_b  = b;
        bus.req_op[i].sign  = sg;
        bus.req_op[i].sat   = st;
    endtask

    task automatic model_clear();
        sb.delete();
        m_valid = 1'b0;
        m_ptr   = '0;
        m_id    = '0;
        m_res   = '0;
        m_cnt   = '0;
    endtask

    // One clock: predict grant/issue before the edge, check the registered side after it.
    task automatic tick();
        logic               accept_m;
        logic [NREQ-1:0]    g;
        logic [IDW-1:0]     gi;
        logic               hs;
        lpmul_arb_resp_type e;
        #1;
        accept_m = !m_valid || bus.resp_ready;
        g  = '0;
        gi = '0;
        for (int k = 0; k < NREQ; k++) begin
            int s;
            s = (int'(m_ptr) + k) % NREQ;
            if (g == '0 && ((bus.req_valid >> s) & NREQ'(1)) != '0) begin
                g  = NREQ'(1) << s;
                gi = IDW'(s);
            end
        end
        hs = accept_m && (g != '0);
        chk("req_ready", 32'(bus.req_ready), 32'(accept_m ? g : '0));
        if (hs) begin
            e.id  = gi;
            e.res = model_mul(bus.req_op[gi]);
            sb.push_back(e);
        end
        if (stat_clr)
            m_cnt = '0;
        else if (|bus.req_valid && !accept_m && m_cnt != '1)
            m_cnt = m_cnt + 16'd1;
        @(posedge clk);
        #1;
        if (hs) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                m_valid = 1'b1;
                m_id    = e.id;
                m_res   = e.res;
                m_ptr   = (int'(e.id) == NREQ - 1) ? '0 : e.id + 2'd1;
            end
        end else if (bus.resp_ready) begin
            m_valid = 1'b0;
        end
        chk("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (m_valid) begin
            chk("resp_id", 32'(bus.resp_id), 32'(m_id));
            chk("resp_res", 32'(bus.resp_res), 32'(m_res));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rst_resp_res", 32'(bus.resp_res), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       tsg[3];
        logic       tst[3];
        logic [15:0] texp[3];
        int start;

        ta  = '{8'd100, 8'd15, 8'h9C};
        tb  = '{8'd2,   8'd17, 8'd2};
        tsg = '{1'b1,   1'b0,  1'b1};
        tst = '{1'b1,   1'b0,  1'b0};
        texp = '{16'h007F, 16'h00FF, 16'hFF38};

        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) bus.req_op[i] = '0;
        model_clear();

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single request from lane 2, saturating signed underflow
        set_req(2, 8'h9C, 8'h03, 1'b1, 1'b1);
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        chk("single_id", 32'(bus.resp_id), 32'd2);
        chk("single_res", 32'(bus.resp_res), 32'hFF80);

        // Arithmetic pass-through vectors
        for (int v = 0; v < 3; v++) begin
            set_req(0, ta[v], tb[v], tsg[v], tst[v]);
            tick();
            bus.req_valid = '0;
            chk("arith_res", 32'(bus.resp_res), 32'(texp[v]));
        end
        tick();

        // Full contention: strict rotation
        for (int i = 0; i < NREQ; i++)
            set_req(i, 8'(i + 1), 8'(i + 3), 1'b0, 1'b0);
        start = int'(m_ptr);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_seq", 32'(bus.resp_id), 32'((start + k) % NREQ));
        end
        bus.req_valid = '0;
        tick();

        // Backpressure with a pending result
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        set_req(0, 8'h81, 8'h7F, 1'b1, 1'b0);
        tick();
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        set_req(1, 8'h10, 8'h10, 1'b0, 1'b1);
        set_req(2, 8'hFF, 8'hFF, 1'b1, 1'b1);
        set_req(3, 8'hFF, 8'hFF, 1'b0, 1'b0);
        #1;
        chk("bp_ready", 32'(bus.req_ready), 32'd0);
        repeat (5) tick();
        chk("bp_stall5", 32'(stall_cnt), 32'd5);
        chk("bp_hold_id", 32'(bus.resp_id), 32'd0);
        bus.resp_ready = 1'b1;
        #1;
        chk("bp_next_grant", 32'(bus.req_ready), 32'h2);
        tick();

        // Mid-stream reset while a result is pending and stalls accumulate
        bus.req_valid[1] = 1'b0;
        bus.resp_ready   = 1'b0;
        repeat (2) tick();
        do_reset();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 8'(i + 5), 8'(i + 9), 1'b1, 1'b0);
        bus.resp_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
        tick();

        // Counter saturation and clear priority
        bus.resp_ready = 1'b0;
        for (int n = 0; n < (1 << CNTW) + 3; n++) tick();
        chk("cnt_sat", 32'(stall_cnt), 32'hFFFF);
        stat_clr = 1'b1;
        tick();
        chk("cnt_clr", 32'(stall_cnt), 32'd0);
        stat_clr = 1'b0;
        tick();
        chk("cnt_after_clr", 32'(stall_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
